// File: rtl/cache_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cache_pkg: FSM state type and address-field width helpers. Rev 1.0
// ------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_REFILL    = 2'd2,
    S_RESPOND   = 2'd3
  } state_t;

  function automatic int offset_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_w, input int sets);
    return addr_w - offset_w(line_w) - index_w(sets);
  endfunction

endpackage
`default_nettype wire

// File: rtl/set_assoc_cache_if.sv
`default_nettype none
// ------------------------------------------------------------------
// set_assoc_cache_if: CPU request bus plus memory beat bus. Rev 1.0
// ------------------------------------------------------------------
interface set_assoc_cache_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 1024,
  parameter int BEAT_W = 32
);
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     addr;
  logic [BEAT_W-1:0]     write_data;
  logic [BEAT_W/8-1:0]   byte_en;
  logic [LINE_W-1:0]     load_data;
  logic                  ready;
  logic                  done;
  logic                  hit;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [BEAT_W-1:0]     mem_wdata;
  logic [BEAT_W-1:0]     mem_rdata;
  logic                  mem_ack;

  // master: requester and memory; slave: the cache
  modport master (
    output read, write, addr, write_data, byte_en, mem_rdata, mem_ack,
    input  load_data, ready, done, hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  read, write, addr, write_data, byte_en, mem_rdata, mem_ack,
    output load_data, ready, done, hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/cache_way_store.sv
`default_nettype none
// ------------------------------------------------------------------
// cache_way_store: tag/valid/dirty/data arrays of one cache way. Rev 1.0
// ------------------------------------------------------------------
module cache_way_store
  import cache_pkg::*;
#(
  parameter int TAG_W  = 21,
  parameter int SETS   = 16,
  parameter int LINE_W = 1024,
  localparam int IDX_W = index_w(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [TAG_W-1:0]  tag_o,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [LINE_W-1:0] data_o,
  input  logic              we_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              dirty_i
);

  logic [TAG_W-1:0]  tag_q   [SETS];
  logic [LINE_W-1:0] data_q  [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;

  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= dirty_i;
    end
  end

  // Payload arrays carry no reset; valid gates every use.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[idx_i]  <= tag_i;
      data_q[idx_i] <= line_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/set_assoc_cache.sv
`default_nettype none
// ------------------------------------------------------------------
// set_assoc_cache: write-back, LRU set-associative line cache. Rev 1.0
// ------------------------------------------------------------------
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 1024,
  parameter int BEAT_W = 32,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  set_assoc_cache_if.slave   bus
);

  localparam int OFF_W  = offset_w(LINE_W);
  localparam int IDX_W  = index_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
  localparam int BYTES  = BEAT_W / 8;
  localparam int BOFF_W = $clog2(BYTES);
  localparam int WIDX_W = OFF_W - BOFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WIDX_W-1:0] LAST_BEAT = WIDX_W'(LINE_W / BEAT_W - 1);

  state_t              state_q;
  logic [TAG_W-1:0]    req_tag_q;
  logic [IDX_W-1:0]    req_idx_q;
  logic [WIDX_W-1:0]   req_widx_q;
  logic [BEAT_W-1:0]   req_wdata_q;
  logic [BYTES-1:0]    req_be_q;
  logic                req_write_q;
  logic [WAY_W-1:0]    victim_q;
  logic [TAG_W-1:0]    victim_tag_q;
  logic [WIDX_W-1:0]   beat_q;
  logic [LINE_W-1:0]   line_buf_q;
  logic [LINE_W-1:0]   load_data_q;
  logic                ready_q, done_q, hit_q, mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [BEAT_W-1:0]   mem_wdata_q;

  logic [TAG_W-1:0]    w_way_tag   [WAYS];
  logic [LINE_W-1:0]   w_way_data  [WAYS];
  logic                w_way_valid [WAYS];
  logic                w_way_dirty [WAYS];
  logic [WAY_W-1:0]    w_age       [WAYS];

  logic                w_idle, w_req_valid, w_hit, w_vic_found;
  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [WAY_W-1:0]    w_hit_way, w_vic, w_best_age;
  logic [WIDX_W-1:0]   w_beat_nxt;
  logic [LINE_W-1:0]   w_fill_line;
  logic                w_store_we, w_store_dirty;
  logic [WAY_W-1:0]    w_store_way;
  logic [LINE_W-1:0]   w_store_line;
  logic                w_lru_upd, w_lru_fill;
  logic [WAY_W-1:0]    w_lru_way;

  function automatic logic [LINE_W-1:0] merge_word(
    input logic [LINE_W-1:0] line, input logic [WIDX_W-1:0] widx,
    input logic [BEAT_W-1:0] wd,   input logic [BYTES-1:0]  be);
    logic [LINE_W-1:0] r;
    r = line;
    for (int b = 0; b < BYTES; b++)
      if (be[b]) r[int'(widx)*BEAT_W + b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Lookup uses the live bus address while idle, the latched request otherwise.
  assign w_idle      = (state_q == S_IDLE);
  assign w_req_valid = bus.read | bus.write;
  assign w_idx       = w_idle ? bus.addr[OFF_W +: IDX_W] : req_idx_q;
  assign w_tag       = w_idle ? bus.addr[ADDR_W-1 -: TAG_W] : req_tag_q;
  assign w_beat_nxt  = beat_q + 1'b1;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_store #(.TAG_W(TAG_W), .SETS(SETS), .LINE_W(LINE_W)) u_store (
      .clk     (clk),
      .rst     (rst),
      .idx_i   (w_idx),
      .tag_o   (w_way_tag[g]),
      .valid_o (w_way_valid[g]),
      .dirty_o (w_way_dirty[g]),
      .data_o  (w_way_data[g]),
      .we_i    (w_store_we && (w_store_way == WAY_W'(g))),
      .tag_i   (w_tag),
      .line_i  (w_store_line),
      .dirty_i (w_store_dirty)
    );
  end

  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_vic      = '0;
    w_vic_found = 1'b0;
    w_best_age = w_age[0];
    for (int w = 0; w < WAYS; w++) begin
      if (w_way_valid[w] && (w_way_tag[w] == w_tag) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_way_valid[w] && !w_vic_found) begin
        w_vic       = WAY_W'(w);
        w_vic_found = 1'b1;
      end
    end
    // Strict compare keeps the lowest index on equal ages.
    if (!w_vic_found) begin
      for (int w = 1; w < WAYS; w++) begin
        if (w_age[w] > w_best_age) begin
          w_best_age = w_age[w];
          w_vic      = WAY_W'(w);
        end
      end
    end
  end

  always_comb begin
    w_fill_line = line_buf_q;
    w_fill_line[LINE_W-BEAT_W +: BEAT_W] = bus.mem_rdata;
    w_store_we    = 1'b0;
    w_store_way   = '0;
    w_store_line  = '0;
    w_store_dirty = 1'b0;
    w_lru_upd     = 1'b0;
    w_lru_way     = '0;
    w_lru_fill    = 1'b0;
    if (w_idle && w_req_valid && w_hit) begin
      w_lru_upd     = 1'b1;
      w_lru_way     = w_hit_way;
      w_store_we    = bus.write;
      w_store_way   = w_hit_way;
      w_store_dirty = 1'b1;
      w_store_line  = merge_word(w_way_data[w_hit_way], bus.addr[OFF_W-1:BOFF_W],
                                 bus.write_data, bus.byte_en);
    end else if ((state_q == S_REFILL) && bus.mem_ack && (beat_q == LAST_BEAT)) begin
      w_lru_upd     = 1'b1;
      w_lru_way     = victim_q;
      w_lru_fill    = 1'b1;
      w_store_we    = 1'b1;
      w_store_way   = victim_q;
      w_store_dirty = req_write_q;
      w_store_line  = req_write_q ? merge_word(w_fill_line, req_widx_q, req_wdata_q, req_be_q)
                                  : w_fill_line;
    end
  end

  if (WAYS > 1) begin : g_lru
    logic [WAY_W-1:0] age_q [SETS][WAYS];
    logic [WAY_W-1:0] w_old_age;

    // A fill ages every other way, so freshly filled ways order correctly.
    assign w_old_age = w_lru_fill ? WAY_W'(WAYS - 1) : w_age[w_lru_way];

    always_comb begin
      for (int w = 0; w < WAYS; w++) w_age[w] = age_q[w_idx][w];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end else if (w_lru_upd) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == w_lru_way) age_q[w_idx][w] <= '0;
          else if (age_q[w_idx][w] < w_old_age) age_q[w_idx][w] <= age_q[w_idx][w] + 1'b1;
        end
      end
    end
  end else begin : g_no_lru
    always_comb begin
      for (int w = 0; w < WAYS; w++) w_age[w] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      req_widx_q   <= '0;
      req_wdata_q  <= '0;
      req_be_q     <= '0;
      req_write_q  <= 1'b0;
      victim_q     <= '0;
      victim_tag_q <= '0;
      beat_q       <= '0;
      line_buf_q   <= '0;
      load_data_q  <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (w_req_valid) begin
          req_tag_q   <= w_tag;
          req_idx_q   <= w_idx;
          req_widx_q  <= bus.addr[OFF_W-1:BOFF_W];
          req_wdata_q <= bus.write_data;
          req_be_q    <= bus.byte_en;
          req_write_q <= bus.write;
          ready_q     <= 1'b0;
          if (w_hit) begin
            if (!bus.write) load_data_q <= w_way_data[w_hit_way];
            hit_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_RESPOND;
          end else begin
            victim_q     <= w_vic;
            victim_tag_q <= w_way_tag[w_vic];
            beat_q       <= '0;
            mem_req_q    <= 1'b1;
            if (w_way_valid[w_vic] && w_way_dirty[w_vic]) begin
              line_buf_q  <= w_way_data[w_vic];
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {w_way_tag[w_vic], w_idx, {OFF_W{1'b0}}};
              mem_wdata_q <= w_way_data[w_vic][BEAT_W-1:0];
              state_q     <= S_WRITEBACK;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {w_tag, w_idx, {OFF_W{1'b0}}};
              state_q     <= S_REFILL;
            end
          end
        end
        S_WRITEBACK: if (bus.mem_ack) begin
          if (beat_q == LAST_BEAT) begin
            beat_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            state_q    <= S_REFILL;
          end else begin
            beat_q      <= w_beat_nxt;
            mem_addr_q  <= {victim_tag_q, req_idx_q, w_beat_nxt, {BOFF_W{1'b0}}};
            mem_wdata_q <= line_buf_q[int'(w_beat_nxt)*BEAT_W +: BEAT_W];
          end
        end
        S_REFILL: if (bus.mem_ack) begin
          line_buf_q[int'(beat_q)*BEAT_W +: BEAT_W] <= bus.mem_rdata;
          if (beat_q == LAST_BEAT) begin
            beat_q    <= '0;
            mem_req_q <= 1'b0;
            if (!req_write_q) load_data_q <= w_fill_line;
            hit_q     <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_RESPOND;
          end else begin
            beat_q     <= w_beat_nxt;
            mem_addr_q <= {req_tag_q, req_idx_q, w_beat_nxt, {BOFF_W{1'b0}}};
          end
        end
        S_RESPOND: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.load_data = load_data_q;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.hit       = hit_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_set_assoc_cache.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_set_assoc_cache: directed bench with a beat-level memory responder. Rev 1.0
// ------------------------------------------------------------------
module tb_set_assoc_cache;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  set_assoc_cache_if bus ();

  set_assoc_cache #(
    .ADDR_W(32), .LINE_W(1024), .BEAT_W(32), .SETS(16), .WAYS(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Memory responder: acks each presented beat after ack_dly low cycles.
  int          ack_dly = 0;
  int          wcnt    = 0;
  int          unstable = 0;
  logic        held    = 1'b0;
  logic [31:0] held_addr, held_wdata;
  logic [31:0] rdata_pat;
  logic [31:0] log_addr  [$];
  logic        log_we    [$];
  logic [31:0] log_wdata [$];

  assign bus.mem_rdata = rdata_pat;

  always @(negedge clk) begin
    if (rst || !bus.mem_req) begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
      held = 1'b0;
    end else begin
      if (held && (bus.mem_addr !== held_addr || bus.mem_wdata !== held_wdata)) unstable++;
      if (wcnt >= ack_dly) begin
        bus.mem_ack = 1'b1;
        wcnt = 0;
        held = 1'b0;
        log_addr.push_back(bus.mem_addr);
        log_we.push_back(bus.mem_we);
        log_wdata.push_back(bus.mem_wdata);
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
        held = 1'b1;
        held_addr  = bus.mem_addr;
        held_wdata = bus.mem_wdata;
      end
    end
  end

  function automatic int count_words(input logic [1023:0] line, input logic [31:0] pat);
    int n = 0;
    for (int i = 0; i < 32; i++) if (line[i*32 +: 32] === pat) n++;
    return n;
  endfunction

  function automatic int bad_beats(input int first, input int n, input logic [31:0] base,
                                   input logic we);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (first + i >= log_addr.size()) bad++;
      else if (log_addr[first+i] !== base + 32'(i*4) || log_we[first+i] !== we) bad++;
    end
    return bad;
  endfunction

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    int guard = 0;
    while (!bus.ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    log_addr.delete();
    log_we.delete();
    log_wdata.delete();
    bus.read = rd; bus.write = wr; bus.addr = a; bus.write_data = wd; bus.byte_en = be;
    @(posedge clk);
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int lat, output logic h);
    issue(rd, wr, a, wd, be);
    lat = 1;
    while (!bus.done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) chk("done_timeout", 64'd0, 64'd1);
    h = bus.hit;
  endtask

  int   lat;
  logic h;
  int   guard;

  initial begin
    rst = 1'b1;
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.write_data = '0; bus.byte_en = '0;
    rdata_pat = 32'h0101_0101;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",   bus.ready,      1);
    chk("rst_done",    bus.done,       0);
    chk("rst_hit",     bus.hit,        0);
    chk("rst_mem_req", bus.mem_req,    0);
    chk("rst_mem_we",  bus.mem_we,     0);
    chk("rst_addr",    bus.mem_addr,   0);
    chk("rst_wdata",   bus.mem_wdata,  0);
    chk("rst_load",    |bus.load_data, 0);
    rst = 1'b0;

    // cold read
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, h);
    chk("cold_lat",   lat, 33);
    chk("cold_hit",   h, 0);
    chk("cold_beats", log_addr.size(), 32);
    chk("cold_addrs", bad_beats(0, 32, 32'h0, 1'b0), 0);
    chk("cold_line",  count_words(bus.load_data, 32'h0101_0101), 32);

    // repeat read hits with no memory traffic
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, h);
    chk("rhit_lat",   lat, 1);
    chk("rhit_hit",   h, 1);
    chk("rhit_beats", log_addr.size(), 0);

    // full and partial write hits
    do_req(1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, lat, h);
    chk("whit_hit",   h, 1);
    chk("whit_lat",   lat, 1);
    chk("whit_beats", log_addr.size(), 0);
    do_req(1'b0, 1'b1, 32'h8, 32'hAAAA_CAFE, 4'h3, lat, h);
    chk("wpart_hit",  h, 1);

    do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, h);
    chk("rback_hit",  h, 1);
    chk("rback_w1",   bus.load_data[32 +: 32], 32'hDEAD_BEEF);
    chk("rback_w2",   bus.load_data[64 +: 32], 32'h0101_CAFE);
    chk("rback_rest", count_words(bus.load_data, 32'h0101_0101), 30);

    // second way of set 0, clean fill
    rdata_pat = 32'h0202_0202;
    do_req(1'b1, 1'b0, 32'h800, 32'h0, 4'h0, lat, h);
    chk("w1_hit",   h, 0);
    chk("w1_lat",   lat, 33);
    chk("w1_addrs", bad_beats(0, 32, 32'h800, 1'b0), 0);

    // conflict: LRU victim is the dirty 0x0 line
    rdata_pat = 32'h0303_0303;
    do_req(1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h0, lat, h);
    chk("evict_hit",    h, 0);
    chk("evict_lat",    lat, 65);
    chk("evict_beats",  log_addr.size(), 64);
    chk("evict_wbaddr", bad_beats(0, 32, 32'h0, 1'b1), 0);
    chk("evict_wb0",    log_wdata[0], 32'h0101_0101);
    chk("evict_wb1",    log_wdata[1], 32'hDEAD_BEEF);
    chk("evict_wb2",    log_wdata[2], 32'h0101_CAFE);
    chk("evict_rfaddr", bad_beats(32, 32, 32'h4000_0000, 1'b0), 0);
    chk("evict_line",   count_words(bus.load_data, 32'h0303_0303), 32);

    // most-recently used way survived the eviction
    do_req(1'b1, 1'b0, 32'h800, 32'h0, 4'h0, lat, h);
    chk("lru_hit", h, 1);
    chk("lru_w0",  bus.load_data[31:0], 32'h0202_0202);

    // read and write together: the write is performed
    do_req(1'b1, 1'b1, 32'h80C, 32'h1234_5678, 4'hF, lat, h);
    chk("rw_hit", h, 1);
    do_req(1'b1, 1'b0, 32'h800, 32'h0, 4'h0, lat, h);
    chk("rw_w3",  bus.load_data[96 +: 32], 32'h1234_5678);

    // slow memory: 3 wait cycles per beat
    ack_dly = 3;
    unstable = 0;
    rdata_pat = 32'h0404_0404;
    do_req(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, lat, h);
    chk("slow_hit",    h, 0);
    chk("slow_lat",    lat, 129);
    chk("slow_addrs",  bad_beats(0, 32, 32'h80, 1'b0), 0);
    chk("slow_stable", unstable, 0);
    chk("slow_line",   count_words(bus.load_data, 32'h0404_0404), 32);
    ack_dly = 0;

    // reset during refill
    rdata_pat = 32'h0505_0505;
    issue(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
    guard = 0;
    while (log_addr.size() < 10 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reached", log_addr.size() >= 10, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready",   bus.ready,   1);
    chk("abort_mem_req", bus.mem_req, 0);
    chk("abort_done",    bus.done,    0);
    rst = 1'b0;
    do_req(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, lat, h);
    chk("abort_rehit", h, 0);
    chk("abort_lat",   lat, 33);
    do_req(1'b1, 1'b0, 32'h800, 32'h0, 4'h0, lat, h);
    chk("abort_clear", h, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
